// File: rtl/routing_crossbar.sv
// routing_crossbar: switch box at a routing-channel intersection.
// Four track bundles cross here: southbound N_i->S_o (32), northbound
// S_i->N_o (16), eastbound W_i->E_o (32) and westbound E_i->W_o (16).
// Each crosspoint bit joins one vertical and one horizontal track in both
// directions. A track with no set crosspoint passes straight through.
// The crosspoints live in a 72 x 32-bit shift chain (prog_i -> prog_o)
// that is daisy-chained with the neighbouring tiles.
//
// Slot map:
//   slots  0..15  SE: slot b,      bit c         = (S track b, E track c)
//   slots 16..23  SW: slot 16+k,   bits[15:0]    = S track 2k,
//                                  bits[31:16]   = S track 2k+1,
//                                  bit within half = W track d
//   slots 24..55  NE: slot 24+a,   bit c         = (N track a, E track c)
//   slots 56..71  NW: slot 56+d,   bit a         = (N track a, W track d)
//
// Routing is purely combinational from the slots, so outputs move while the
// chain shifts; the routing is meaningful only once prog_shft is low.
module routing_crossbar (
  input  logic        clk,
  input  logic        nres,
  input  logic [31:0] prog_i,
  input  logic        prog_shft,
  output logic [31:0] prog_o,
  input  logic [31:0] N_i,
  output logic [31:0] S_o,
  input  logic [15:0] S_i,
  output logic [15:0] N_o,
  input  logic [31:0] W_i,
  output logic [31:0] E_o,
  input  logic [15:0] E_i,
  output logic [15:0] W_o
);

  // Configuration chain; slot[0] is the word nearest the chain output.
  logic [71:0][31:0] slot;

  // Transposed views of the crosspoint planes so every output track can be
  // reduced from a single vector.
  logic [31:0][31:0] ne_col;  // ne_col[c][a] = NE crosspoint (N a, E c)
  logic [31:0][15:0] se_col;  // se_col[c][b] = SE crosspoint (S b, E c)
  logic [15:0][15:0] sw_col;  // sw_col[d][b] = SW crosspoint (S b, W d)
  logic [31:0][15:0] nw_row;  // nw_row[a][d] = NW crosspoint (N a, W d)

  // Shift chain: new words enter at slot 71 and leave from slot 0.
  always_ff @(posedge clk or posedge nres) begin
    if (nres) begin
      slot <= '0;
    end else if (prog_shft) begin
      slot <= {prog_i, slot[71:1]};
    end
  end

  // The chain output is slot 0 itself, so it is registered by construction.
  assign prog_o = slot[0];

  genvar i, j;

  // Regroup the stored crosspoints by the track they serve.
  for (i = 0; i < 32; i++) begin : g_ne_col_c
    for (j = 0; j < 32; j++) begin : g_ne_col_a
      assign ne_col[i][j] = slot[24 + j][i];
    end
    for (j = 0; j < 16; j++) begin : g_se_col_b
      assign se_col[i][j] = slot[j][i];
    end
    for (j = 0; j < 16; j++) begin : g_nw_row_d
      assign nw_row[i][j] = slot[56 + j][i];
    end
  end

  for (i = 0; i < 16; i++) begin : g_sw_col_d
    for (j = 0; j < 16; j++) begin : g_sw_col_b
      assign sw_col[i][j] = slot[16 + (j / 2)][((j % 2) * 16) + i];
    end
  end

  // Eastbound outputs: vertical inputs turned east, else W_i straight on.
  for (i = 0; i < 32; i++) begin : g_e_out
    logic hit;
    logic turned;
    assign hit    = (|ne_col[i]) | (|se_col[i]);
    assign turned = (|(ne_col[i] & N_i)) | (|(se_col[i] & S_i));
    assign E_o[i] = hit ? turned : W_i[i];
  end

  // Westbound outputs: vertical inputs turned west, else E_i straight on.
  for (i = 0; i < 16; i++) begin : g_w_out
    logic hit;
    logic turned;
    assign hit    = (|slot[56 + i]) | (|sw_col[i]);
    assign turned = (|(slot[56 + i] & N_i)) | (|(sw_col[i] & S_i));
    assign W_o[i] = hit ? turned : E_i[i];
  end

  // Southbound outputs: horizontal inputs turned south, else N_i straight on.
  for (i = 0; i < 32; i++) begin : g_s_out
    logic hit;
    logic turned;
    assign hit    = (|slot[24 + i]) | (|nw_row[i]);
    assign turned = (|(slot[24 + i] & W_i)) | (|(nw_row[i] & E_i));
    assign S_o[i] = hit ? turned : N_i[i];
  end

  // Northbound outputs: horizontal inputs turned north, else S_i straight on.
  for (i = 0; i < 16; i++) begin : g_n_out
    logic        hit;
    logic        turned;
    logic [15:0] sw_row;
    assign sw_row = slot[16 + (i / 2)][((i % 2) * 16) +: 16];
    assign hit    = (|slot[i]) | (|sw_row);
    assign turned = (|(slot[i] & W_i)) | (|(sw_row & E_i));
    assign N_o[i] = hit ? turned : S_i[i];
  end

endmodule

// File: tb/tb_routing_crossbar.sv
// tb_routing_crossbar: directed checks of the switch box with hand-computed
// expected values for reset pass-through, chain latency, several crosspoint
// patterns, OR merging and reset during a shift burst.
module tb_routing_crossbar;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nres;
  logic [31:0] prog_i;
  logic        prog_shft;
  logic [31:0] prog_o;
  logic [31:0] N_i;
  logic [31:0] S_o;
  logic [15:0] S_i;
  logic [15:0] N_o;
  logic [31:0] W_i;
  logic [31:0] E_o;
  logic [15:0] E_i;
  logic [15:0] W_o;

  routing_crossbar dut (
    .clk       (clk),
    .nres      (nres),
    .prog_i    (prog_i),
    .prog_shft (prog_shft),
    .prog_o    (prog_o),
    .N_i       (N_i),
    .S_o       (S_o),
    .S_i       (S_i),
    .N_o       (N_o),
    .W_i       (W_i),
    .E_o       (E_o),
    .E_i       (E_i),
    .W_o       (W_o)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag,
                               input logic [31:0] exp_s, input logic [15:0] exp_n,
                               input logic [31:0] exp_e, input logic [15:0] exp_w);
    check({tag, ".S_o"}, S_o, exp_s);
    check({tag, ".N_o"}, {16'h0, N_o}, {16'h0, exp_n});
    check({tag, ".E_o"}, E_o, exp_e);
    check({tag, ".W_o"}, {16'h0, W_o}, {16'h0, exp_w});
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] cfg [72];

  task automatic set_default_tracks();
    N_i = 32'h8765_4321;
    S_i = 16'ha5a5;
    W_i = 32'h0fed_cba9;
    E_i = 16'h5a5a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nres = 1'b1;
    @(negedge clk);
    nres = 1'b0;
  endtask

  // One shifting edge; returns #1 after the rising edge with prog_shft low.
  task automatic shift_word(input logic [31:0] w);
    @(negedge clk);
    prog_i    = w;
    prog_shft = 1'b1;
    @(posedge clk);
    #1;
    prog_shft = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < 72; k++) cfg[k] = 32'h0;
  endtask

  // Word shifted in n-th lands in slot n, so send cfg[0] first.
  task automatic load_cfg();
    for (int k = 0; k < 72; k++) shift_word(cfg[k]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nres      = 1'b1;
    prog_i    = 32'h0;
    prog_shft = 1'b0;
    set_default_tracks();

    // Reset pass-through.
    #1;
    check("rst.prog_o", prog_o, 32'h0);
    check_outputs("rst", 32'h8765_4321, 16'ha5a5, 32'h0fed_cba9, 16'h5a5a);
    @(negedge clk);
    nres = 1'b0;

    // Chain latency with a pause mid-burst.
    shift_word(32'hdead_beef);
    for (int k = 2; k <= 40; k++) shift_word(32'h0);
    idle_cycles(3);
    check("lat.hold_mid", prog_o, 32'h0);
    for (int k = 41; k <= 71; k++) shift_word(32'h0);
    check("lat.edge71", prog_o, 32'h0);
    shift_word(32'h0);
    check("lat.edge72", prog_o, 32'hdead_beef);
    idle_cycles(4);
    check("lat.hold72", prog_o, 32'hdead_beef);
    shift_word(32'h0);
    check("lat.edge73", prog_o, 32'h0);
    check_outputs("lat.zero", 32'h8765_4321, 16'ha5a5, 32'h0fed_cba9, 16'h5a5a);

    // NE anti-diagonal: E_o and S_o become bit-reversed N_i and W_i.
    do_reset();
    clear_cfg();
    for (int k = 0; k < 32; k++) cfg[24 + k] = 32'h1 << (31 - k);
    load_cfg();
    check_outputs("ne_diag", 32'h95d3_b7f0, 16'ha5a5, 32'h84c2_a6e1, 16'h5a5a);

    // SW single point joining S track 0 and W track 0.
    do_reset();
    clear_cfg();
    cfg[16] = 32'h0000_0001;
    load_cfg();
    check_outputs("sw_pt", 32'h8765_4321, 16'ha5a4, 32'h0fed_cba9, 16'h5a5b);

    // SW upper half: slot 17 bit 16+1 joins S track 3 and W track 1.
    // W_o[1] = S_i[3] = 0, N_o[3] = E_i[1] = 1.
    do_reset();
    clear_cfg();
    cfg[17] = 32'h0002_0000;
    load_cfg();
    check_outputs("sw_hi", 32'h8765_4321, 16'ha5ad, 32'h0fed_cba9, 16'h5a58);

    // NW point joining N track 5 and W track 0.
    do_reset();
    clear_cfg();
    cfg[56] = 32'h0000_0020;
    load_cfg();
    check_outputs("nw_pt", 32'h8765_4301, 16'ha5a5, 32'h0fed_cba9, 16'h5a5b);

    // SE point joining S track 2 and E track 4.
    do_reset();
    clear_cfg();
    cfg[2] = 32'h0000_0010;
    load_cfg();
    check_outputs("se_pt", 32'h8765_4321, 16'ha5a1, 32'h0fed_cbb9, 16'h5a5a);

    // OR merge of NE[0][0] and SE[0][0] on E track 0.
    do_reset();
    clear_cfg();
    cfg[0]  = 32'h0000_0001;
    cfg[24] = 32'h0000_0001;
    N_i = 32'h8765_4320;
    load_cfg();
    check_outputs("or.s1", 32'h8765_4321, 16'ha5a5, 32'h0fed_cba9, 16'h5a5a);
    S_i = 16'ha5a4;
    #1;
    check_outputs("or.s0", 32'h8765_4321, 16'ha5a5, 32'h0fed_cba8, 16'h5a5a);
    set_default_tracks();

    // Reset in the middle of a burst of all-ones words.
    do_reset();
    for (int k = 0; k < 30; k++) shift_word(32'hffff_ffff);
    check("mid.pre_prog_o", prog_o, 32'h0);
    #2;
    nres = 1'b1;
    #1;
    check("mid.prog_o", prog_o, 32'h0);
    check_outputs("mid", 32'h8765_4321, 16'ha5a5, 32'h0fed_cba9, 16'h5a5a);
    @(negedge clk);
    nres = 1'b0;

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
